staged_state_selector: RTL and testbench

- Board-level operator-input FSM for the DE-series boards.
- Three active-low push-buttons step a staged (pending) state up or down and commit it to the live state.
- A commit counter and a pending indicator drive the LEDs.
- Generalises the fixed 4-state button selector:
  - parametrised state count, counter width and wrap/saturate mode;
  - on-chip synchronisation and debouncing;
  - a single clock domain, replacing per-button edge clocking.

---
 rtl/staged_state_selector.sv | 147 ++++++++++++++
 tb/tb_staged_state_selector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/staged_state_selector.sv
// Operator-input selector: debounced push-buttons step a staged value up/down and commit it
// to the live state; a commit counter, a one-cycle commit strobe and a pending flag go to the LEDs.
//
// register     | meaning
// -------------+---------------------------------------------------------
// staged       | value the operator is dialling in, stepped by KEY[1]/KEY[0]
// state        | live value, loaded from staged on a KEY[2] commit
// commit_count | number of commits, wraps at 2^COUNT_W
// armed        | per button: a released level has been seen since reset
module staged_state_selector #(
    parameter int STATE_W         = 2,
    parameter int NUM_STATES      = 4,
    parameter int COUNT_W         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit WRAP            = 1'b1
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic [2:0]         KEY,
    output logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] staged,
    output logic [COUNT_W-1:0] commit_count,
    output logic               pending,
    output logic               commit_pulse
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);

    logic [2:0]      sync_a;
    logic [2:0]      sync_b;
    logic [2:0]      sync_prev;
    logic [2:0]      deb;
    logic [2:0]      armed;
    logic [2:0]      accept;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];
    logic [1:0]      flush_cnt;
    logic            settled;

    logic               up_ev;
    logic               dn_ev;
    logic               commit_ev;
    logic               staged_illegal;
    logic [STATE_W-1:0] staged_nxt;

    // sync_a/sync_b/sync_prev only carry real samples three edges after reset
    assign settled = (flush_cnt == 2'd3);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_a    <= 3'b111;
            sync_b    <= 3'b111;
            sync_prev <= 3'b111;
            deb       <= 3'b111;
            armed     <= 3'b000;
            flush_cnt <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a    <= KEY;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
            if (!settled) begin
                flush_cnt <= flush_cnt + 2'd1;
            end
            for (int i = 0; i < 3; i++) begin
                if (settled && sync_b[i] && sync_prev[i]) begin
                    armed[i] <= 1'b1;
                end
                if ((sync_b[i] == deb[i]) || (sync_b[i] != sync_prev[i])) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A press is taken on the same edge that the debounced level falls
    always_comb begin
        accept = '0;
        press  = '0;
        for (int i = 0; i < 3; i++) begin
            accept[i] = (sync_b[i] != deb[i]) && (sync_b[i] == sync_prev[i])
                        && (db_cnt[i] == DB_LAST);
            press[i]  = accept[i] && !sync_b[i] && armed[i];
        end
    end

    assign dn_ev     = press[0];
    assign up_ev     = press[1];
    assign commit_ev = press[2];

    generate
        if (NUM_STATES < (1 << STATE_W)) begin : g_illegal
            assign staged_illegal = (staged > LAST_STATE);
        end else begin : g_full
            assign staged_illegal = 1'b0;
        end
    endgenerate

    always_comb begin
        staged_nxt = staged;
        if (up_ev ^ dn_ev) begin
            if (staged_illegal) begin
                staged_nxt = '0;
            end else if (up_ev) begin
                if (staged == LAST_STATE) begin
                    staged_nxt = WRAP ? '0 : staged;
                end else begin
                    staged_nxt = staged + STATE_W'(1);
                end
            end else begin
                if (staged == '0) begin
                    staged_nxt = WRAP ? LAST_STATE : staged;
                end else begin
                    staged_nxt = staged - STATE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= '0;
            staged       <= '0;
            commit_count <= '0;
            commit_pulse <= 1'b0;
        end else begin
            staged       <= staged_nxt;
            commit_pulse <= commit_ev;
            if (commit_ev) begin
                state        <= staged;
                commit_count <= commit_count + COUNT_W'(1);
            end
        end
    end

    assign pending = (staged != state);

endmodule

// File: tb/tb_staged_state_selector.sv
// Bench for staged_state_selector: directed plan steps plus a random press sequence,
// checked against an arithmetic model of the operator-visible behaviour.
module tb_staged_state_selector;

    localparam int NS = 4;
    localparam int CW = 4;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] key_a = 3'b111;
    logic [2:0] key_b = 3'b111;

    logic [1:0] state_a, staged_a, state_b, staged_b;
    logic [3:0] count_a, count_b;
    logic       pending_a, pending_b, pulse_a, pulse_b;

    int total = 0;
    int bad = 0;

    int m_state = 0, m_staged = 0, m_count = 0, m_pulses = 0;
    int s_staged = 0;

    int   pulse_seen = 0;
    int   pulse_wide = 0;
    logic pulse_prev = 1'b0;

    always #5 clk = ~clk;

    staged_state_selector #(
        .STATE_W(2), .NUM_STATES(NS), .COUNT_W(CW), .DEBOUNCE_CYCLES(DB), .WRAP(1'b1)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key_a),
        .state(state_a), .staged(staged_a), .commit_count(count_a),
        .pending(pending_a), .commit_pulse(pulse_a)
    );

    staged_state_selector #(
        .STATE_W(2), .NUM_STATES(NS), .COUNT_W(CW), .DEBOUNCE_CYCLES(DB), .WRAP(1'b0)
    ) dut_sat (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key_b),
        .state(state_b), .staged(staged_b), .commit_count(count_b),
        .pending(pending_b), .commit_pulse(pulse_b)
    );

    always @(negedge clk) begin
        if (pulse_a) pulse_seen++;
        if (pulse_a && pulse_prev) pulse_wide++;
        pulse_prev = pulse_a;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int step_ref(input int cur, input bit up, input bit dn, input bit wrap);
        if (up == dn) return cur;
        if (up) return wrap ? (cur + 1) % NS : ((cur + 1 > NS - 1) ? NS - 1 : cur + 1);
        return wrap ? (cur + NS - 1) % NS : ((cur == 0) ? 0 : cur - 1);
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".state"},   32'(state_a),   32'(m_state));
        check({tag, ".staged"},  32'(staged_a),  32'(m_staged));
        check({tag, ".count"},   32'(count_a),   32'(m_count));
        check({tag, ".pending"}, 32'(pending_a), 32'(m_staged != m_state));
        check({tag, ".pulses"},  32'(pulse_seen), 32'(m_pulses));
        check({tag, ".wide"},    32'(pulse_wide), 32'(0));
        check({tag, ".sat"},     32'(staged_b),  32'(s_staged));
    endtask

    task automatic model_press(input logic [2:0] ma, input logic [2:0] mb);
        if (ma[2]) begin
            m_state  = m_staged;
            m_count  = (m_count + 1) % (1 << CW);
            m_pulses = m_pulses + 1;
        end
        m_staged = step_ref(m_staged, ma[1], ma[0], 1'b1);
        s_staged = step_ref(s_staged, mb[1], mb[0], 1'b0);
    endtask

    task automatic press(input logic [2:0] ma, input logic [2:0] mb, input int hold, input int gap);
        key_a = ~ma;
        key_b = ~mb;
        tick(hold);
        key_a = 3'b111;
        key_b = 3'b111;
        tick(gap);
        model_press(ma, mb);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst.state",  32'(state_a),  32'(0));
        check("rst.staged", 32'(staged_a), 32'(0));
        check("rst.count",  32'(count_a),  32'(0));
        check("rst.pulse",  32'(pulse_a),  32'(0));
        tick(2);
        rst_n = 1'b1;
        tick(5);
        m_state = 0; m_staged = 0; m_count = 0; s_staged = 0;
    endtask

    initial begin
        logic [2:0] rm;
        int hold, gap;

        // 1: reset and idle
        tick(1);
        do_reset();
        tick(20);
        check_all("idle");

        // 2: exact press latency, release is silent, then commit
        key_a = 3'b101;
        tick(6);
        check("lat.early", 32'(staged_a), 32'(0));
        tick(1);
        check("lat.exact", 32'(staged_a), 32'(1));
        check("lat.pending", 32'(pending_a), 32'(1));
        tick(3);
        key_a = 3'b111;
        tick(10);
        model_press(3'b010, 3'b000);
        check_all("release");
        press(3'b100, 3'b000, 10, 10);
        check_all("commit1");

        // 3: bouncing up press, wrap vs saturate
        do_reset();
        for (int i = 0; i < 6; i++) begin
            key_a[1] = i[0];
            key_b[1] = i[0];
            tick(2);
        end
        key_a[1] = 1'b0;
        key_b[1] = 1'b0;
        tick(10);
        key_a = 3'b111;
        key_b = 3'b111;
        tick(10);
        model_press(3'b010, 3'b010);
        check_all("bounce");
        for (int i = 0; i < 3; i++) press(3'b010, 3'b010, 9, 10);
        check_all("wrap_sat");
        press(3'b000, 3'b010, 9, 10);
        check_all("sat_hold");

        // 4: down wrap, simultaneous up+down
        do_reset();
        press(3'b001, 3'b001, 9, 10);
        check_all("down_wrap");
        press(3'b011, 3'b011, 9, 10);
        check_all("up_dn");

        // 5: commit and step together
        do_reset();
        press(3'b010, 3'b000, 9, 10);
        press(3'b010, 3'b000, 9, 10);
        press(3'b110, 3'b000, 9, 10);
        check_all("commit_step");

        // 6: counter wrap, then reset mid-debounce with button held
        do_reset();
        for (int i = 0; i < 15; i++) press(3'b100, 3'b000, 8, 10);
        check_all("count15");
        press(3'b100, 3'b000, 8, 10);
        check_all("count_wrap");
        key_a = 3'b101;
        tick(4);
        do_reset();
        tick(20);
        check_all("held_reset");
        key_a = 3'b111;
        tick(10);
        check_all("held_release");
        press(3'b010, 3'b000, 9, 10);
        check_all("repress");

        // random operator sequences, with occasional short glitches
        for (int n = 0; n < 30; n++) begin
            rm = 3'($urandom_range(1, 7));
            hold = $urandom_range(8, 14);
            gap = $urandom_range(10, 14);
            if ($urandom_range(0, 1) == 1) begin
                key_a = ~rm;
                tick($urandom_range(1, 2));
                key_a = 3'b111;
                tick(4);
            end
            press(rm, 3'b000, hold, gap);
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
